// File: rtl/axis_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_arb_pkg : shared types and round-robin helper for axis_rr_arb    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package axis_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_PAUSED} arb_state_e;

  localparam int STAT_W    = 16;
  // Upper bound on the port count that rr_next can scan.
  localparam int MAX_PORTS = 32;

  // Returns the first requesting index after 'last', wrapping modulo n.
  // The scan runs farthest-first so the nearest requester overwrites the result.
  function automatic int unsigned rr_next(input logic [MAX_PORTS-1:0] req,
                                          input int unsigned last,
                                          input int unsigned n);
    int unsigned idx;
    rr_next = last;
    for (int unsigned k = MAX_PORTS; k >= 1; k--) begin
      if (k <= n) begin
        idx = (last + k) % n;
        if (req[idx[4:0]]) rr_next = idx;
      end
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_skid_reg : 2-entry registered valid/ready buffer                 |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module axis_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q,  out_data_d;
  logic         sk_valid_q,  sk_valid_d;
  logic [W-1:0] sk_data_q,   sk_data_d;

  // Ready depends only on registered state, so m_ready never reaches s_ready.
  assign s_ready = !sk_valid_q;
  assign m_valid = out_valid_q;
  assign m_data  = out_data_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sk_valid_d  = sk_valid_q;
    sk_data_d   = sk_data_q;
    if (!out_valid_q || m_ready) begin
      if (sk_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = sk_data_q;
        sk_valid_d  = 1'b0;
      end else begin
        out_valid_d = s_valid;
        if (s_valid) out_data_d = s_data;
      end
    end else if (s_valid && !sk_valid_q) begin
      sk_valid_d = 1'b1;
      sk_data_d  = s_data;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sk_valid_q  <= 1'b0;
      sk_data_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sk_valid_q  <= sk_valid_d;
      sk_data_q   <= sk_data_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_rr_arb : N-input AXI-Stream round-robin frame arbiter            |
// | Optional per-port frame counters: define AXIS_RR_ARB_STATS_EN         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module axis_rr_arb
  import axis_arb_pkg::*;
#(
  parameter  int N_PORTS = 4,
  parameter  int DATA_W  = 8,
  parameter  int KEEP_W  = (DATA_W + 7) / 8,
  parameter  int USR_W   = 1,
  localparam int SEL_W   = $clog2(N_PORTS)
) (
  input  logic                      clk,
  input  logic                      arst_n,
  input  logic [N_PORTS*DATA_W-1:0] s_tdata,
  input  logic [N_PORTS*KEEP_W-1:0] s_tkeep,
  input  logic [N_PORTS*USR_W-1:0]  s_tuser,
  input  logic [N_PORTS-1:0]        s_tlast,
  input  logic [N_PORTS-1:0]        s_tvalid,
  output logic [N_PORTS-1:0]        s_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic [KEEP_W-1:0]         m_tkeep,
  output logic [USR_W-1:0]          m_tuser,
  output logic                      m_tlast,
  output logic [SEL_W-1:0]          m_tid,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  input  logic                      pause_req,
  output logic                      pause_ack,
  output logic [SEL_W-1:0]          grant_idx,
  output logic                      busy
`ifdef AXIS_RR_ARB_STATS_EN
  ,
  output logic [N_PORTS*STAT_W-1:0] stat_frames
`endif
);

  localparam int PAY_W = SEL_W + 1 + USR_W + KEEP_W + DATA_W;

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic             in_valid, in_ready, push;
  logic [PAY_W-1:0] in_pay, out_pay;

  assign in_valid  = (state_q == ARB_BUSY) && s_tvalid[grant_q];
  assign push      = in_valid && in_ready;
  assign in_pay    = {grant_q, s_tlast[grant_q], s_tuser[grant_q*USR_W +: USR_W],
                      s_tkeep[grant_q*KEEP_W +: KEEP_W], s_tdata[grant_q*DATA_W +: DATA_W]};
  assign busy      = (state_q == ARB_BUSY);
  assign pause_ack = (state_q == ARB_PAUSED) && pause_req;
  assign grant_idx = grant_q;

  always_comb begin
    s_tready = '0;
    if (state_q == ARB_BUSY) s_tready[grant_q] = in_ready;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (pause_req) begin
          state_d = ARB_PAUSED;
        end else if (|s_tvalid) begin
          grant_d = SEL_W'(rr_next(MAX_PORTS'(s_tvalid), 32'(grant_q), N_PORTS));
          state_d = ARB_BUSY;
        end
      end
      // The grant is held until the tlast beat is taken; pause waits for it.
      ARB_BUSY:   if (push && s_tlast[grant_q]) state_d = ARB_IDLE;
      ARB_PAUSED: if (!pause_req) state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ARB_IDLE;
      grant_q <= SEL_W'(N_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  axis_skid_reg #(.W(PAY_W)) u_skid (
    .clk     (clk),
    .arst_n  (arst_n),
    .s_valid (in_valid),
    .s_ready (in_ready),
    .s_data  (in_pay),
    .m_valid (m_tvalid),
    .m_ready (m_tready),
    .m_data  (out_pay)
  );

  assign {m_tid, m_tlast, m_tuser, m_tkeep, m_tdata} = out_pay;

`ifdef AXIS_RR_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [N_PORTS];
  logic [STAT_W-1:0] stat_d [N_PORTS];

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      stat_d[i] = stat_q[i];
      if (s_tvalid[i] && s_tready[i] && s_tlast[i] && (stat_q[i] != '1))
        stat_d[i] = stat_q[i] + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < N_PORTS; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) stat_q[i] <= stat_d[i];
    end
  end

  for (genvar g = 0; g < N_PORTS; g++) begin : g_stat
    assign stat_frames[g*STAT_W +: STAT_W] = stat_q[g];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_rr_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axis_rr_arb : directed self-checking bench for axis_rr_arb         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_axis_rr_arb;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         arst_n;
  logic [N*8-1:0] s_tdata;
  logic [N-1:0] s_tkeep, s_tuser, s_tlast, s_tvalid, s_tready;
  logic [7:0]   m_tdata;
  logic [0:0]   m_tkeep, m_tuser;
  logic         m_tlast, m_tvalid, m_tready;
  logic [1:0]   m_tid, grant_idx;
  logic         pause_req, pause_ack, busy;
`ifdef AXIS_RR_ARB_STATS_EN
  logic [N*16-1:0] stat_frames;
`endif

  always #5 clk = ~clk;

  axis_rr_arb u_dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .s_tdata   (s_tdata),
    .s_tkeep   (s_tkeep),
    .s_tuser   (s_tuser),
    .s_tlast   (s_tlast),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .m_tdata   (m_tdata),
    .m_tkeep   (m_tkeep),
    .m_tuser   (m_tuser),
    .m_tlast   (m_tlast),
    .m_tid     (m_tid),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .pause_req (pause_req),
    .pause_ack (pause_ack),
    .grant_idx (grant_idx),
    .busy      (busy)
`ifdef AXIS_RR_ARB_STATS_EN
    ,
    .stat_frames (stat_frames)
`endif
  );

  typedef struct {
    int         tid;
    logic [7:0] d;
    logic       last;
    int         cyc;
  } beat_t;

  beat_t      got[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;

  // Per-port producer state
  int         frames_left[N];
  int         flen[N];
  int         bidx[N];
  int         sent[N];
  logic [7:0] base[N];
  logic [N-1:0] en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      s_tvalid[p]         = en[p] && (frames_left[p] > 0);
      s_tdata[p*8 +: 8]   = base[p] + 8'(sent[p]);
      s_tlast[p]          = (bidx[p] == flen[p] - 1);
      s_tkeep[p]          = 1'b1;
      s_tuser[p]          = 1'b0;
    end
  endtask

  task automatic prod_init();
    for (int p = 0; p < N; p++) begin
      frames_left[p] = 0;
      flen[p]        = 1;
      bidx[p]        = 0;
      sent[p]        = 0;
      base[p]        = 8'h00;
    end
    en = '0;
  endtask

  // Observe handshakes mid-cycle, then advance producers just after the edge.
  task automatic tick();
    logic [N-1:0] acc;
    beat_t b;
    @(negedge clk);
    acc = s_tvalid & s_tready;
    if (m_tvalid && m_tready) begin
      b.tid = int'(m_tid); b.d = m_tdata; b.last = m_tlast; b.cyc = cyc;
      got.push_back(b);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < N; p++) begin
      if (acc[p]) begin
        sent[p]++;
        bidx[p]++;
        if (bidx[p] == flen[p]) begin
          bidx[p] = 0;
          frames_left[p]--;
        end
      end
    end
    drive();
  endtask

  task automatic do_reset();
    arst_n    = 1'b0;
    m_tready  = 1'b1;
    pause_req = 1'b0;
    prod_init();
    drive();
    got.delete();
    repeat (2) @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int         exp_tid[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    logic [0:0] rdy[8]      = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset values
    do_reset();
    check("rst_s_tready", 32'(s_tready), 32'h0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'h0);
    check("rst_m_tdata",  32'(m_tdata),  32'h0);
    check("rst_m_tid",    32'(m_tid),    32'h0);
    check("rst_pause_ack", 32'(pause_ack), 32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_grant",    32'(grant_idx), 32'd3);

    // Single 3-beat frame on port 0: A1, A2, A3
    en = 4'b0001; frames_left[0] = 1; flen[0] = 3; base[0] = 8'hA1;
    drive();
    tick();
    check("t1_s_tready", 32'(s_tready), 32'b0001);
    check("t1_grant",    32'(grant_idx), 32'd0);
    check("t1_busy",     32'(busy), 32'd1);
    tick();
    check("t1_b0_data", {m_tvalid, m_tlast, 6'(m_tid), m_tdata}, {1'b1, 1'b0, 6'd0, 8'hA1});
    tick();
    check("t1_b1_data", {m_tvalid, m_tlast, 6'(m_tid), m_tdata}, {1'b1, 1'b0, 6'd0, 8'hA2});
    tick();
    check("t1_b2_data", {m_tvalid, m_tlast, 6'(m_tid), m_tdata}, {1'b1, 1'b1, 6'd0, 8'hA3});
    check("t1_busy_end", 32'(busy), 32'd0);
    tick();
    check("t1_m_tvalid_end", 32'(m_tvalid), 32'd0);

    // All ports request 2-beat frames; port 0 has a second frame
    do_reset();
    en = 4'b1111;
    for (int p = 0; p < N; p++) begin
      frames_left[p] = (p == 0) ? 2 : 1;
      flen[p] = 2;
      base[p] = 8'(8'h10 * (p + 1));
    end
    drive();
    repeat (22) tick();
    check("t2_count", 32'(got.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      if (i < got.size()) check("t2_tid", 32'(got[i].tid), 32'(exp_tid[i]));
    for (int i = 0; i < 9; i++)
      if (i + 1 < got.size()) check("t2_gap", 32'(got[i+1].cyc - got[i].cyc), (i % 2 == 1) ? 32'd2 : 32'd1);

    // Port 2 frame under output backpressure
    do_reset();
    en = 4'b0100; frames_left[2] = 1; flen[2] = 4; base[2] = 8'hC0;
    drive();
    tick();
    for (int j = 0; j < 8; j++) begin
      m_tready = rdy[j];
      tick();
      if (j == 2) begin
        check("t3_skid_full_s_tready", 32'(s_tready), 32'b0000);
        check("t3_stall0", {m_tvalid, m_tdata}, {1'b1, 8'hC1});
      end
      if (j == 3) check("t3_stall1", {m_tvalid, m_tdata, s_tready}, {1'b1, 8'hC1, 4'b0000});
      if (j == 4) check("t3_resume", {m_tdata, s_tready}, {8'hC2, 4'b0100});
    end
    check("t3_count", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) check("t3_beat", {got[i].last, got[i].d}, {(i == 3), 8'(8'hC0 + i)});

    // Pause requested mid-frame
    do_reset();
    en = 4'b1111;
    for (int p = 0; p < N; p++) begin
      frames_left[p] = 1;
      flen[p] = (p == 0) ? 4 : 2;
      base[p] = 8'(8'h10 * p);
    end
    drive();
    repeat (3) tick();
    pause_req = 1'b1;
    tick();
    check("t4_midframe", {busy, pause_ack}, {1'b1, 1'b0});
    tick();
    check("t4_frame_done", {busy, pause_ack}, {1'b0, 1'b0});
    tick();
    check("t4_paused_ack", 32'(pause_ack), 32'd1);
    repeat (2) tick();
    check("t4_no_grant", {s_tready, busy, 2'(grant_idx)}, {4'b0000, 1'b0, 2'd0});
    pause_req = 1'b0;
    #1;
    check("t4_ack_drop", 32'(pause_ack), 32'd0);
    repeat (2) tick();
    check("t4_next_grant", {2'(grant_idx), s_tready}, {2'd1, 4'b0010});

    // Requester drops tvalid mid-frame, then reset mid-frame
    do_reset();
    en = 4'b0010; frames_left[1] = 1; flen[1] = 4; base[1] = 8'h50;
    drive();
    repeat (3) tick();
    en = 4'b0001; frames_left[0] = 1; flen[0] = 1; base[0] = 8'h60;
    drive();
    repeat (2) tick();
    check("t5_hold_grant", {2'(grant_idx), s_tready, busy}, {2'd1, 4'b0010, 1'b1});
    arst_n = 1'b0;
    #1;
    check("t5_rst_async", {m_tvalid, s_tready, busy, 2'(grant_idx)}, {1'b0, 4'b0000, 1'b0, 2'd3});
    prod_init();
    en = 4'b0011;
    frames_left[0] = 1; flen[0] = 1; base[0] = 8'h60;
    frames_left[1] = 1; flen[1] = 2; base[1] = 8'h70;
    drive();
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    tick();
    check("t5_grant_after_rst", {2'(grant_idx), s_tready}, {2'd0, 4'b0001});

`ifdef AXIS_RR_ARB_STATS_EN
    // Frame counters: 3 frames on port 1, 1 frame on port 3
    do_reset();
    en = 4'b1010;
    frames_left[1] = 3; flen[1] = 1; base[1] = 8'h11;
    frames_left[3] = 1; flen[3] = 1; base[3] = 8'h33;
    drive();
    repeat (15) tick();
    check("stat_p0", 32'(stat_frames[0  +: 16]), 32'd0);
    check("stat_p1", 32'(stat_frames[16 +: 16]), 32'd3);
    check("stat_p2", 32'(stat_frames[32 +: 16]), 32'd0);
    check("stat_p3", 32'(stat_frames[48 +: 16]), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
